// File: rtl/timer_multi_if.sv
// Control/status bundle between protocol FSMs and the multi-channel timer.
// With TIMER_MULTI_STATUS_EN defined it also carries sticky status, its clear and irq.
interface timer_multi_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
);
  logic [CHANNELS-1:0]       enbl;
  logic [CHANNELS-1:0]       mode;
  logic [CHANNELS*WIDTH-1:0] value;
  logic [CHANNELS-1:0]       done;
  logic                      tick;
`ifdef TIMER_MULTI_STATUS_EN
  logic [CHANNELS-1:0]       status_clr;
  logic [CHANNELS-1:0]       status;
  logic                      irq;

  modport master (output enbl, mode, value, status_clr, input done, tick, status, irq);
  modport slave  (input enbl, mode, value, status_clr, output done, tick, status, irq);
`else
  modport master (output enbl, mode, value, input done, tick);
  modport slave  (input enbl, mode, value, output done, tick);
`endif
endinterface

// File: rtl/timer_multi.sv
// Shared-prescaler multi-channel one-shot/periodic timer.
// Optional sticky status and irq logic is enabled by defining TIMER_MULTI_STATUS_EN.
module timer_multi #(
  parameter int FCLK     = 1000000,
  parameter int SCALE    = 1000,
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) (
  input  logic          clk,
  input  logic          rst,
  timer_multi_if.slave  bus
);
  localparam int DIV = FCLK / SCALE;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_e;

  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic                tick_q, tick_d;
  state_e              state_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_q   [CHANNELS];
  logic [CHANNELS-1:0] mode_q;
  logic [CHANNELS-1:0] done_q;

  always_comb begin
    tick_d = (pcnt_q == PMAX);
    pcnt_d = tick_d ? '0 : pcnt_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  // Dropping enbl beats any same-cycle expiry, so it is handled ahead of the state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < CHANNELS; n++) begin
        state_q[n] <= IDLE;
        cnt_q[n]   <= '0;
      end
      mode_q <= '0;
      done_q <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (!bus.enbl[n]) begin
          state_q[n] <= IDLE;
          cnt_q[n]   <= '0;
          done_q[n]  <= 1'b0;
        end else begin
          case (state_q[n])
            IDLE: begin
              mode_q[n] <= bus.mode[n];
              if (bus.value[n*WIDTH +: WIDTH] == '0) begin
                state_q[n] <= EXPIRED;
                done_q[n]  <= 1'b1;
              end else begin
                cnt_q[n]   <= bus.value[n*WIDTH +: WIDTH];
                state_q[n] <= RUN;
              end
            end
            RUN: begin
              done_q[n] <= 1'b0;
              if (tick_q) begin
                if (cnt_q[n] != WIDTH'(1)) begin
                  cnt_q[n] <= cnt_q[n] - WIDTH'(1);
                end else if (!mode_q[n] || bus.value[n*WIDTH +: WIDTH] == '0) begin
                  state_q[n] <= EXPIRED;
                  cnt_q[n]   <= '0;
                  done_q[n]  <= 1'b1;
                end else begin
                  cnt_q[n]  <= bus.value[n*WIDTH +: WIDTH];
                  mode_q[n] <= bus.mode[n];
                  done_q[n] <= 1'b1;
                end
              end
            end
            default: done_q[n] <= 1'b1;
          endcase
        end
      end
    end
  end

  assign bus.done = done_q;
  assign bus.tick = tick_q;

`ifdef TIMER_MULTI_STATUS_EN
  logic [CHANNELS-1:0] expire;
  logic [CHANNELS-1:0] status_q, status_d;
  logic                irq_q;

  // expire marks the edge on which done rises, so status sets together with done.
  always_comb begin
    expire = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      expire[n] = bus.enbl[n] & ~done_q[n] &
                  (((state_q[n] == IDLE) & (bus.value[n*WIDTH +: WIDTH] == '0)) |
                   ((state_q[n] == RUN) & tick_q & (cnt_q[n] == WIDTH'(1))));
    end
    status_d = (status_q & ~bus.status_clr) | expire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= |status_q;
    end
  end

  assign bus.status = status_q;
  assign bus.irq    = irq_q;
`endif
endmodule

// File: doc/timer_multi.md
# timer_multi

Multi-channel millisecond-class timer: one shared prescaler divides `clk` down to a timebase tick of FCLK/SCALE cycles, and CHANNELS independent down-counters each run in one-shot or periodic mode. It is the parametrised successor of the single-channel TIMER and uses the same FCLK/SCALE convention and the same `enbl`/`value`/`done` semantics. It sits beside protocol FSMs that need several concurrent timeouts or heartbeats.

## Interface
- FCLK, 1000000: clock frequency in Hz.
- SCALE, 1000: tick rate in Hz. DIV = FCLK/SCALE must be ≥ 1.
- CHANNELS, 4: number of independent timers, ≥ 1.
- WIDTH, 16: counter and `value` width per channel.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enbl  in  CHANNELS  per-channel run request. A level: 1 runs the channel, 0 stops and clears it.
- mode  in  CHANNELS  per-channel mode: 0 = one-shot, 1 = periodic. Sampled on every load.
- value  in  CHANNELS*WIDTH  period in ticks. Channel n uses bits [n*WIDTH +: WIDTH].
- done  out  CHANNELS  expiry indication; see Operation.
- tick  out  1  registered timebase strobe, one cycle wide.

## Operation
- Prescaler:
  - Counter `pcnt` runs 0..DIV-1 and is free-running from reset.
  - `tick` is high for the one cycle after `pcnt` == DIV-1, then `pcnt` wraps to 0.
  - With DIV = 1, `tick` is high every cycle after reset.
  - The prescaler is shared by all channels and is never restarted by `enbl`.
- Per-channel FSM, states IDLE, RUN, EXPIRED; counter `cnt` is WIDTH bits:
  - IDLE, `enbl`=1, `value`≠0: load `cnt`=`value`, go to RUN.
  - IDLE, `enbl`=1, `value`=0: go to EXPIRED. `done` rises on the next edge.
  - RUN, `tick`=1, `cnt`>1: `cnt` decrements by 1.
  - RUN, `tick`=1, `cnt`=1, `mode`=0: go to EXPIRED; `done` is set and held.
  - RUN, `tick`=1, `cnt`=1, `mode`=1: reload `cnt` from the current `value`, stay in RUN, `done` pulses high for exactly one cycle. If `value`=0 at reload, the channel goes to EXPIRED and `done` is held.
  - EXPIRED: `done` stays 1 while `enbl`=1. Further ticks are ignored.
  - Any state, `enbl`=0: go to IDLE on the next edge with `cnt`=0 and `done`=0. This has priority over a simultaneous expiry, so no `done` is produced.
- Changing `value` while in RUN has no effect until the next load or reload.
- There is no arithmetic wrap: `cnt` never decrements below 1 inside RUN.
- Channels are fully independent. Simultaneous expiries on several channels are all reported in the same cycle.

## Timing
- Reset values: `pcnt`=0, `tick`=0, all channels IDLE, `cnt`=0, `done`=0. With the macro enabled, `status`=0 and `irq`=0.
- Asserting `rst` mid-count aborts every channel immediately (asynchronously). After `rst` falls, a channel whose `enbl` is still high reloads on the first edge, as if `enbl` had just risen.
- Load latency: the channel is in RUN one edge after `enbl` is sampled high.
- Expiry latency: `done` is registered and rises on the edge that samples the Nth `tick` after load.
- One-shot duration from the load edge: between (N-1)·DIV+1 and N·DIV cycles. The error is up to one tick because the prescaler phase is shared across channels.
- Periodic mode: once running, successive `done` pulses are exactly N·DIV cycles apart.

## Configuration
- Macro `TIMER_MULTI_STATUS_EN`:
  - Defined: adds input `status_clr` [CHANNELS], output `status` [CHANNELS] and output `irq` [1].
  - `status[n]` is set by every `done` rising edge on channel n and cleared by `status_clr[n]`=1. If a set and a clear land in the same cycle, the set wins.
  - `irq` is the registered OR of `status`, so it lags `status` by one cycle.
  - `status` is not cleared by `enbl`=0.
  - Undefined: those ports and that logic do not exist; all other behaviour is identical.

## Test plan
- FCLK=8, SCALE=2 (DIV=4), CHANNELS=2, WIDTH=8. Release `rst`, hold `enbl`=0 → `tick` every 4 cycles, `done`=0.
- Ch0 one-shot, `value`=5, raise `enbl` → `done[0]` rises 17–20 cycles after the load edge and stays high. Dropping `enbl` clears `done[0]` one edge later.
- Ch1 periodic, `value`=3 → first pulse within 9–12 cycles, then 1-cycle `done[1]` pulses exactly every 12 cycles. Changing `value` to 2 mid-count takes effect only after the next pulse, giving an 8-cycle spacing.
- `value`=0 with `enbl` rising → `done` high one edge later. Dropping `enbl` on the same edge as the expiring `tick` → no `done`, channel IDLE.
- `rst` pulsed while ch0 is mid-count with `enbl` held high → `done`=0 and `tick`=0 immediately. The channel reloads after `rst` falls and expires at the full period again.
- With `TIMER_MULTI_STATUS_EN`: ch0 expires → `status[0]`=1, then `irq`=1 one cycle later. Pulse `status_clr[0]` on the same cycle as a new ch0 expiry → `status[0]` stays 1. A later clear alone drops `status[0]`, then `irq`.
